sample_readout_ctrl: RTL and testbench

Sequencer that drains captured samples from the sample RAM to the UART transmitter after a capture completes. It walks the RAM backwards from the last-written address and reads (read_count+1)*4 words. For each word it serializes only the enabled 8-bit channel groups, lane 0 first. It sits between the capture core (start, configuration), the sample RAM read port and the UART tx byte interface.

---
 rtl/sample_readout_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sample_readout_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_readout_ctrl.sv
// Drains captured samples from the sample RAM to the UART, newest word first, one byte per enabled lane.
// Optional READOUT_CHECKSUM_EN appends an XOR checksum byte after the last sample byte.
module sample_readout_ctrl #(
    parameter int MEM_AW = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [MEM_AW-1:0] start_addr,
    input  logic [CNT_W-1:0]  read_count,
    input  logic [3:0]        channel_disable,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_dat,
    output logic [7:0]        tx_dat,
    output logic              tx_vld,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              done
);

`ifdef READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_CKSUM, S_FINISH} state_t;
    localparam state_t S_LAST = S_CKSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_FINISH} state_t;
    localparam state_t S_LAST = S_FINISH;
`endif

    // (read_count+1)*4; the single overflowing value (all-ones) saturates to the largest multiple of 4
    function automatic logic [CNT_W+1:0] words_sat(input logic [CNT_W-1:0] rc);
        logic [CNT_W+2:0] w;
        w = {1'b0, rc, 2'b00} + (CNT_W+3)'(4);
        if (w[CNT_W+2])
            return {{CNT_W{1'b1}}, 2'b00};
        return w[CNT_W+1:0];
    endfunction

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MEM_AW-1:0] r_addr;
    logic [CNT_W+1:0]  r_remaining;
    logic [3:0]        r_en_mask;
    logic [1:0]        r_lane;
    logic [31:0]       r_word;
    logic [3:0]        w_above;
    logic              w_has_next;
    logic [1:0]        w_next_lane;
    logic [1:0]        w_first_lane;
    logic              w_hs;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]        r_cksum;
`endif

    assign w_above      = r_en_mask & (4'b1110 << r_lane);
    assign w_has_next   = |w_above;
    assign w_next_lane  = lowest_lane(w_above);
    assign w_first_lane = lowest_lane(r_en_mask);
    assign w_hs         = tx_vld && tx_rdy;

    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        mem_addr    = r_addr;
        tx_dat      = 8'h00;
        tx_vld      = 1'b0;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = (channel_disable == 4'hF) ? S_LAST : S_FETCH;
            end
            S_FETCH: begin
                mem_rd      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: w_state_nxt = S_SEND;
            S_SEND: begin
                tx_vld = 1'b1;
                tx_dat = r_word[{r_lane, 3'b000} +: 8];
                if (tx_rdy && !w_has_next)
                    w_state_nxt = (r_remaining == (CNT_W+2)'(1)) ? S_LAST : S_FETCH;
            end
`ifdef READOUT_CHECKSUM_EN
            S_CKSUM: begin
                tx_vld = 1'b1;
                tx_dat = r_cksum;
                if (tx_rdy)
                    w_state_nxt = S_FINISH;
            end
`endif
            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // abort also masks this cycle's strobes so an in-flight byte is never accepted
        if (abort) begin
            w_state_nxt = S_IDLE;
            mem_rd      = 1'b0;
            tx_vld      = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_en_mask   <= 4'h0;
            r_lane      <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_addr      <= start_addr;
                        r_remaining <= words_sat(read_count);
                        r_en_mask   <= ~channel_disable;
                    end
                end
                S_WAIT: r_lane <= w_first_lane;
                S_SEND: begin
                    if (w_hs) begin
                        if (w_has_next) begin
                            r_lane <= w_next_lane;
                        end else begin
                            r_remaining <= r_remaining - (CNT_W+2)'(1);
                            r_addr      <= r_addr - MEM_AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_WAIT)
            r_word <= mem_dat;
    end

`ifdef READOUT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start)
            r_cksum <= 8'h00;
        else if (r_state == S_SEND && w_hs)
            r_cksum <= r_cksum ^ tx_dat;
    end
`endif

endmodule

// File: tb/tb_sample_readout_ctrl.sv
// Bench for sample_readout_ctrl: vector table of readout configurations, byte/address scoreboard,
// plus hand sequences for abort, start/abort collision and reset.
module tb_sample_readout_ctrl;

    localparam int MEM_AW = 12;
    localparam int CNT_W  = 16;
`ifdef READOUT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [MEM_AW-1:0] start_addr;
    logic [CNT_W-1:0]  read_count;
    logic [3:0]        channel_disable;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_dat;
    logic [7:0]        tx_dat;
    logic              tx_vld;
    logic              tx_rdy;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    sample_readout_ctrl #(.MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .read_count(read_count), .channel_disable(channel_disable),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dat(mem_dat),
        .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .busy(busy), .done(done)
    );

    logic [31:0] ram [0:4095];
    always @(posedge clk) if (mem_rd) mem_dat <= ram[mem_addr];

    typedef struct {
        logic [11:0] addr;
        logic [15:0] rc;
        logic [3:0]  dis;
        int          rdy;
        int          exp_words;
        int          exp_bytes;
        logic [7:0]  first;
    } vec_t;

    vec_t        vecs [7];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_bytes [$];
    logic [11:0] exp_addrs [$];
    int          bytes_seen = 0;
    int          words_seen = 0;
    int          done_seen  = 0;
    int          rdy_pct    = 100;
    logic [7:0]  first_seen = 8'h00;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_dat   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && !abort) begin
                check("tx_vld_hold", {31'd0, tx_vld}, 32'd1);
                check("tx_dat_hold", {24'd0, tx_dat}, {24'd0, prev_dat});
            end
            if (tx_vld && tx_rdy) begin
                if (bytes_seen == 0) first_seen = tx_dat;
                if (exp_bytes.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL byte_extra actual=%0h required=none", tx_dat);
                end else begin
                    check("byte", {24'd0, tx_dat}, {24'd0, exp_bytes.pop_front()});
                end
                bytes_seen++;
            end
            if (mem_rd) begin
                if (exp_addrs.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL addr_extra actual=%0h required=none", mem_addr);
                end else begin
                    check("mem_addr", {20'd0, mem_addr}, {20'd0, exp_addrs.pop_front()});
                end
                words_seen++;
            end
            if (done) done_seen++;
            prev_stall = tx_vld && !tx_rdy;
            prev_dat   = tx_dat;
        end
    end

    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_rdy = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic model(input logic [11:0] a, input logic [15:0] rc, input logic [3:0] dis);
        int nw;
        logic [11:0] ad;
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  ck;
        nw = (int'(rc) + 1) * 4;
        ad = a;
        ck = 8'h00;
        if (dis != 4'hF) begin
            for (int k = 0; k < nw; k++) begin
                exp_addrs.push_back(ad);
                w = ram[ad];
                for (int l = 0; l < 4; l++) begin
                    if (!dis[l]) begin
                        b = w[8*l +: 8];
                        exp_bytes.push_back(b);
                        ck = ck ^ b;
                    end
                end
                ad = ad - 12'd1;
            end
        end
`ifdef READOUT_CHECKSUM_EN
        exp_bytes.push_back(ck);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0;
        bytes_seen = 0;
        words_seen = 0;
        d0 = done_seen;
        rdy_pct = v.rdy;
        model(v.addr, v.rc, v.dis);
        @(posedge clk); #1;
        start = 1'b1; start_addr = v.addr; read_count = v.rc; channel_disable = v.dis;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = 12'($urandom); read_count = 16'($urandom); channel_disable = 4'($urandom);
        check($sformatf("v%0d_busy_start", idx), {31'd0, busy}, 32'd1);
        if (CK == 0 && v.dis == 4'hF)
            check($sformatf("v%0d_done_latency", idx), {31'd0, done}, 32'd1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done_seen != d0) break;
            @(posedge clk); #1;
            if (idx == 1 && cyc == 10) begin
                start = 1'b1; start_addr = 12'h123; read_count = 16'd5; channel_disable = 4'h0;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check($sformatf("v%0d_done_count", idx), done_seen - d0, 32'd1);
        check($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_done_end", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d_words", idx), words_seen, v.exp_words);
        check($sformatf("v%0d_bytes", idx), bytes_seen, v.exp_bytes + CK);
        if (v.exp_bytes + CK > 0)
            check($sformatf("v%0d_first", idx), {24'd0, first_seen}, {24'd0, v.first});
        check($sformatf("v%0d_left", idx), exp_bytes.size() + exp_addrs.size(), 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
    endtask

    initial begin
        int d0;
        for (int a = 0; a < 4096; a++) ram[a] = $urandom;
        for (int k = 0; k < 4; k++) ram[5-k] = 32'h44332211 + k;
        ram[12'h100] = 32'hA1B2C3D4;
        ram[12'h001] = 32'h000000EE;
        ram[12'h800] = 32'h99887766;
        ram[12'h000] = 32'h5A000000;

        vecs[0] = '{12'h005, 16'd0, 4'h0, 100, 4, 16, 8'h11};
        vecs[1] = '{12'h100, 16'd1, 4'hA, 100, 8, 16, 8'hD4};
        vecs[2] = '{12'h001, 16'd0, 4'h0, 100, 4, 16, 8'hEE};
        vecs[3] = '{12'h005, 16'd0, 4'h0, 30,  4, 16, 8'h11};
        vecs[4] = '{12'h800, 16'd2, 4'h6, 50, 12, 24, 8'h66};
        vecs[5] = '{12'h000, 16'd0, 4'h7, 100, 4,  4, 8'h5A};
        vecs[6] = '{12'h300, 16'd3, 4'hF, 100, 0,  0, 8'h00};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = '0; read_count = '0; channel_disable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_tx_dat", {24'd0, tx_dat}, 32'd0);
        check("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // abort while the third byte of the second word is on the wire
        rdy_pct = 100;
        bytes_seen = 0;
        words_seen = 0;
        d0 = done_seen;
        model(12'h005, 16'd0, 4'h0);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 12'h005; read_count = 16'd0; channel_disable = 4'h0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bytes_seen >= 6) break;
            @(posedge clk); #1;
        end
        check("abort_bytes_before", bytes_seen, 32'd6);
        check("abort_inflight_vld", {31'd0, tx_vld}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_tx_vld", {31'd0, tx_vld}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", done_seen - d0, 32'd0);
        check("abort_bytes_after", bytes_seen, 32'd6);
        exp_bytes.delete();
        exp_addrs.delete();
        run_vec(vecs[0], 7);

        // abort and start together: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; start_addr = 12'h010; read_count = 16'd0; channel_disable = 4'h0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("collide_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("collide_idle_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
